// File: rtl/gearbox_src_arbiter_pkg.sv
// rtl/gearbox_src_arbiter_pkg.sv - shared types and defaults for the gearbox source arbiter
package gbx_pkg;

    localparam int GBX_LEN_W_DEF    = 8;
    localparam int GBX_WDOG_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } gbx_state_e;

    typedef logic gbx_ch_t;

endpackage

// File: rtl/gearbox_src_arbiter_if.sv
// rtl/gearbox_src_arbiter_if.sv - two upstream request channels plus downstream beat port
interface gearbox_src_arbiter_if #(
    parameter int LEN_W = gbx_pkg::GBX_LEN_W_DEF
);
    logic [127:0]     req0_data;
    logic             req0_valid;
    logic             req0_ready;
    logic [LEN_W-1:0] req0_len;
    logic [127:0]     req1_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [LEN_W-1:0] req1_len;
    logic [127:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_src;
    logic             busy;
    logic             err_timeout;

    modport master (
        output req0_data, req0_valid, req0_len,
        output req1_data, req1_valid, req1_len,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_data, out_valid, out_last, out_src, busy, err_timeout
    );

    modport slave (
        input  req0_data, req0_valid, req0_len,
        input  req1_data, req1_valid, req1_len,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_data, out_valid, out_last, out_src, busy, err_timeout
    );
endinterface

// File: rtl/gearbox_src_arbiter_wdog.sv
// rtl/gearbox_src_arbiter_wdog.sv - mid-packet stall counter, used when GBX_ARB_WDOG_EN is defined
module gbx_arb_wdog #(
    parameter int WDOG_CYC = gbx_pkg::GBX_WDOG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    input  logic accept_i,
    output logic timeout_o
);
    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall;

    assign stall = busy_i && !accept_i;
    // Fires on the stall cycle that brings the count up to WDOG_CYC.
    assign timeout_o = stall && (stall_cnt_q == CNT_W'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy_i || accept_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_q != CNT_W'(WDOG_CYC)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/gearbox_src_arbiter.sv
// rtl/gearbox_src_arbiter.sv - packet-granular 2:1 source arbiter ahead of a 128-to-32 gearbox; watchdog abort under GBX_ARB_WDOG_EN
module gearbox_src_arbiter
    import gbx_pkg::*;
#(
    parameter int LEN_W    = GBX_LEN_W_DEF,
    parameter int WDOG_CYC = GBX_WDOG_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    gearbox_src_arbiter_if.slave bus
);
    gbx_state_e       state_q;
    gbx_ch_t          sel_q;
    gbx_ch_t          last_grant_q;
    logic [LEN_W-1:0] remaining_q;

    logic             in_busy;
    logic             sel_valid;
    logic             accept;
    logic             timeout;
    gbx_ch_t          winner;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] grant_len;

    assign in_busy   = (state_q == BUSY);
    assign sel_valid = sel_q ? bus.req1_valid : bus.req0_valid;

    assign bus.out_valid  = in_busy && sel_valid;
    assign bus.out_data   = in_busy ? (sel_q ? bus.req1_data : bus.req0_data) : '0;
    assign bus.req0_ready = in_busy && !sel_q && bus.out_ready;
    assign bus.req1_ready = in_busy &&  sel_q && bus.out_ready;
    assign bus.out_last   = in_busy && (remaining_q == LEN_W'(1));
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_src    = sel_q;

    assign accept = bus.out_valid && bus.out_ready;

    // On contention the channel that did not win last time gets the packet.
    assign winner    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign win_len   = winner ? bus.req1_len : bus.req0_len;
    assign grant_len = (win_len == '0) ? LEN_W'(1) : win_len;

`ifdef GBX_ARB_WDOG_EN
    gbx_arb_wdog #(
        .WDOG_CYC(WDOG_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .busy_i   (in_busy),
        .accept_i (accept),
        .timeout_o(timeout)
    );
    assign bus.err_timeout = (state_q == ABORT);
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (WDOG_CYC == 0);
    assign timeout         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            remaining_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        sel_q       <= winner;
                        remaining_q <= grant_len;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q      <= IDLE;
                            last_grant_q <= sel_q;
                        end
                    end else if (timeout) begin
                        state_q      <= ABORT;
                        last_grant_q <= sel_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gearbox_src_arbiter.sv
// tb/tb_gearbox_src_arbiter.sv - directed self-checking bench for gearbox_src_arbiter
module tb_gearbox_src_arbiter;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    gearbox_src_arbiter_if #(.LEN_W(8)) bus ();

    gearbox_src_arbiter #(
        .LEN_W   (8),
        .WDOG_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_req0_ready"}, bus.req0_ready, 0);
        chk({tag, "_req1_ready"}, bus.req1_ready, 0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_out_src"}, bus.out_src, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [3:0] order;
        order    = 4'b1010;
        n_assert = 0;
        n_fail   = 0;

        rst = 1'b1;
        bus.req0_data = '0; bus.req0_valid = 1'b0; bus.req0_len = '0;
        bus.req1_data = '0; bus.req1_valid = 1'b0; bus.req1_len = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");

        // Lone channel 0, len 3: one bubble then three beats.
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_len = 8'd3; bus.req0_data = 128'hA000; bus.out_ready = 1'b1;
        #1;
        chk("r35_bubble_valid", bus.out_valid, 0);
        chk("r35_bubble_ready0", bus.req0_ready, 0);
        step();
        chk("r35_b1_valid", bus.out_valid, 1);
        chk("r35_b1_ready0", bus.req0_ready, 1);
        chk("r35_b1_data", bus.out_data, 128'hA000);
        chk("r35_b1_last", bus.out_last, 0);
        chk("r35_b1_busy", bus.busy, 1);
        step();
        bus.req0_data = 128'hA001; #1;
        chk("r35_b2_data", bus.out_data, 128'hA001);
        chk("r35_b2_last", bus.out_last, 0);
        chk("r35_b2_ready0", bus.req0_ready, 1);
        step();
        bus.req0_data = 128'hA002; #1;
        chk("r35_b3_data", bus.out_data, 128'hA002);
        chk("r35_b3_last", bus.out_last, 1);
        chk("r35_b3_ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0; #1;
        chk("r35_after_ready0", bus.req0_ready, 0);
        chk("r35_after_busy", bus.busy, 0);

        // Both channels valid, len 2 each, from reset: order 0,1,0,1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_len = 8'd2; bus.req0_data = 128'hB0;
        bus.req1_valid = 1'b1; bus.req1_len = 8'd2; bus.req1_data = 128'hB1;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk("r36_idle_busy", bus.busy, 0);
            chk("r36_idle_valid", bus.out_valid, 0);
            step();
            chk("r36_src", bus.out_src, order[p]);
            chk("r36_b1_valid", bus.out_valid, 1);
            chk("r36_b1_data", bus.out_data, order[p] ? 128'hB1 : 128'hB0);
            chk("r36_b1_ready0", bus.req0_ready, !order[p]);
            chk("r36_b1_ready1", bus.req1_ready, order[p]);
            chk("r36_b1_last", bus.out_last, 0);
            step();
            chk("r36_b2_last", bus.out_last, 1);
            step();
        end

        // Length 0 on channel 1 moves exactly one beat.
        bus.req0_valid = 1'b0;
        bus.req1_len = 8'd0; bus.req1_data = 128'hC1;
        #1;
        step();
        chk("r37_valid", bus.out_valid, 1);
        chk("r37_last", bus.out_last, 1);
        chk("r37_src", bus.out_src, 1);
        chk("r37_ready1", bus.req1_ready, 1);
        chk("r37_data", bus.out_data, 128'hC1);
        step();
        bus.req1_valid = 1'b0; #1;
        chk("r37_after_busy", bus.busy, 0);

        // Downstream stall of 5 cycles inside a len 4 packet.
        bus.req0_valid = 1'b1; bus.req0_len = 8'd4; bus.req0_data = 128'hD0;
        #1;
        step();
        chk("r38_b1_data", bus.out_data, 128'hD0);
        chk("r38_b1_last", bus.out_last, 0);
        step();
        bus.req0_data = 128'hD1; bus.out_ready = 1'b0; bus.req0_len = 8'd1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("r38_stall_data", bus.out_data, 128'hD1);
            chk("r38_stall_valid", bus.out_valid, 1);
            chk("r38_stall_last", bus.out_last, 0);
            chk("r38_stall_ready0", bus.req0_ready, 0);
            step();
        end
        bus.out_ready = 1'b1; #1;
        chk("r38_b2_ready0", bus.req0_ready, 1);
        chk("r38_b2_last", bus.out_last, 0);
        step();
        bus.req0_data = 128'hD2; #1;
        chk("r38_b3_last", bus.out_last, 0);
        step();
        bus.req0_data = 128'hD3; #1;
        chk("r38_b4_data", bus.out_data, 128'hD3);
        chk("r38_b4_last", bus.out_last, 1);
        step();
        bus.req0_valid = 1'b0; #1;
        chk("r38_after_busy", bus.busy, 0);

        // Upstream valid drop mid-packet holds the grant.
        bus.req1_valid = 1'b1; bus.req1_len = 8'd2; bus.req1_data = 128'hE0;
        #1;
        step();
        chk("r22_b1_src", bus.out_src, 1);
        chk("r22_b1_valid", bus.out_valid, 1);
        step();
        bus.req1_valid = 1'b0; bus.req0_valid = 1'b1; bus.req0_len = 8'd4; bus.req0_data = 128'hF0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("r22_gap_valid", bus.out_valid, 0);
            chk("r22_gap_busy", bus.busy, 1);
            chk("r22_gap_src", bus.out_src, 1);
            chk("r22_gap_ready0", bus.req0_ready, 0);
            step();
        end
        bus.req1_valid = 1'b1; bus.req1_data = 128'hE1; #1;
        chk("r22_b2_data", bus.out_data, 128'hE1);
        chk("r22_b2_last", bus.out_last, 1);
        step();
        bus.req1_valid = 1'b0; #1;
        chk("r22_after_busy", bus.busy, 0);
        step();
        chk("wd_b1_src", bus.out_src, 0);
        chk("wd_b1_valid", bus.out_valid, 1);
`ifdef GBX_ARB_WDOG_EN
        // Channel 0 stalls after beat 1; abort 9 cycles later, then pending channel 1.
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; bus.req1_len = 8'd1; bus.req1_data = 128'h61;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk("r39_wait_err", bus.err_timeout, 0);
            chk("r39_wait_busy", bus.busy, 1);
            step();
        end
        chk("r39_abort_err", bus.err_timeout, 1);
        chk("r39_abort_valid", bus.out_valid, 0);
        chk("r39_abort_ready1", bus.req1_ready, 0);
        step();
        chk("r39_idle_err", bus.err_timeout, 0);
        chk("r39_idle_busy", bus.busy, 0);
        step();
        chk("r39_next_src", bus.out_src, 1);
        chk("r39_next_data", bus.out_data, 128'h61);
        chk("r39_next_last", bus.out_last, 1);
        step();
        bus.req1_valid = 1'b0;
`else
        repeat (3) step();
        chk("wd_b4_last", bus.out_last, 1);
        chk("wd_b4_err", bus.err_timeout, 0);
        step();
        bus.req0_valid = 1'b0;
`endif

        // One-beat channel 0 packet, so last_grant is 0 before the reset test.
        bus.req0_valid = 1'b1; bus.req0_len = 8'd1; bus.req0_data = 128'h70;
        #1;
        step();
        chk("r40_pre_last", bus.out_last, 1);
        step();
        bus.req0_len = 8'd5; #1;
        step();
        chk("r40_b1_last", bus.out_last, 0);
        step();
        rst = 1'b1; bus.req1_valid = 1'b1; bus.req1_len = 8'd2;
        #1;
        chk("r40_b2_busy", bus.busy, 1);
        step();
        chk_reset_outputs("r40_reset");
        rst = 1'b0; #1;
        chk("r40_idle_busy", bus.busy, 0);
        step();
        chk("r40_grant_src", bus.out_src, 0);
        chk("r40_grant_valid", bus.out_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
